// File: rtl/result_checker_if.sv
// Snooped data-memory store bus, golden-table load port and checker results,
// bundled so the checker and its driver share one connection point.
interface result_checker_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ERR_W  = 8,
  parameter int DUR_W  = 16
);
  localparam int IDX_W = $clog2(DEPTH);

  // Snooped store bus
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;

  // Golden-table load port
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;

  // Run results
  logic [ERR_W-1:0]  error_num;
  logic [DUR_W-1:0]  duration;
  logic              finish;
  logic              timed_out;
  logic              first_err_valid;
  logic [IDX_W-1:0]  first_err_idx;
  logic [DATA_W-1:0] first_err_data;
  logic [IDX_W:0]    checked;

  modport master (
    output addr, data, wen, ld_en, ld_idx, ld_data,
    input  error_num, duration, finish, timed_out, first_err_valid,
           first_err_idx, first_err_data, checked
  );

  modport slave (
    input  addr, data, wen, ld_en, ld_idx, ld_data,
    output error_num, duration, finish, timed_out, first_err_valid,
           first_err_idx, first_err_data, checked
  );
endinterface

// File: rtl/result_checker.sv
// Self-checking result monitor: arms on the begin symbol stored to the test
// port, compares each later test-port store with a loadable golden table and
// reports error count, duration, first mismatch and timeout.
module result_checker #(
  parameter int                ADDR_W     = 30,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT  = 30'h10,
  parameter logic [DATA_W-1:0] BEGIN_SYM  = 32'h00000168,
  parameter int                CHECK_NUM  = 19,
  parameter int                DEPTH      = 32,
  parameter int                ERR_W      = 8,
  parameter int                DUR_W      = 16,
  parameter int                TIMEOUT    = 0,
  parameter bit                SWAP_BYTES = 1'b1
) (
  input logic             clk,
  input logic             rst,
  result_checker_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;
  localparam logic [IDX_W:0]   CHK_N = (IDX_W+1)'(CHECK_NUM);
  localparam logic [DUR_W-1:0] TMO_V = DUR_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = d[(NB-1-i)*8 +: 8];
    return r;
  endfunction

  // Saturating add of a (small) count onto the error counter.
  function automatic logic [ERR_W-1:0] err_sat_add(input logic [ERR_W-1:0] a,
                                                   input logic [IDX_W:0]   b);
    logic [ERR_W+IDX_W+1:0] s;
    s = {{(IDX_W+2){1'b0}}, a} + {{(ERR_W+1){1'b0}}, b};
    if (|s[ERR_W+IDX_W+1:ERR_W]) return '1;
    return s[ERR_W-1:0];
  endfunction

  function automatic logic [DUR_W-1:0] dur_sat_inc(input logic [DUR_W-1:0] d);
    if (&d) return d;
    return d + 1'b1;
  endfunction

  state_t            state_q;
  logic              held_q;
  logic [ERR_W-1:0]  err_q;
  logic [DUR_W-1:0]  dur_q;
  logic [IDX_W:0]    chk_q;
  logic              fin_q;
  logic              to_q;
  logic              fev_q;
  logic [IDX_W-1:0]  fidx_q;
  logic [DATA_W-1:0] fdata_q;
  logic [DATA_W-1:0] gold_q [DEPTH];

  logic [DATA_W-1:0] dm_d;
  logic [DUR_W-1:0]  dur_d;
  logic              hit, accept, mismatch, done, tmo_hit;

  assign dm_d     = SWAP_BYTES ? byte_swap(bus.data) : bus.data;
  assign hit      = bus.wen && (bus.addr == TEST_PORT);
  assign accept   = hit && !held_q;
  assign mismatch = dm_d != gold_q[chk_q[IDX_W-1:0]];
  assign done     = chk_q == CHK_N;
  assign tmo_hit  = (TIMEOUT != 0) && (dur_q == TMO_V);
  assign dur_d    = dur_sat_inc(dur_q);

  // Stall filter: a store held across several cycles is seen once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) held_q <= 1'b0;
    else      held_q <= bus.wen;
  end

  // Golden table: writable only while idle, deliberately kept across reset.
  always_ff @(posedge clk) begin
    if (bus.ld_en && state_q == IDLE) gold_q[bus.ld_idx] <= bus.ld_data;
  end

  // Run control: IDLE -> CHECK on begin symbol, CHECK -> REPORT on count/timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      err_q   <= '1;
      dur_q   <= '0;
      chk_q   <= '0;
      fin_q   <= 1'b0;
      to_q    <= 1'b0;
      fev_q   <= 1'b0;
      fidx_q  <= '0;
      fdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit && dm_d == BEGIN_SYM) begin
            state_q <= CHECK;
            err_q   <= '0;
          end
        end
        CHECK: begin
          if (done) begin
            state_q <= REPORT;
            fin_q   <= 1'b1;
            dur_q   <= dur_d;
          end else if (tmo_hit) begin
            state_q <= REPORT;
            fin_q   <= 1'b1;
            to_q    <= 1'b1;
            err_q   <= err_sat_add(err_q, CHK_N - chk_q);
          end else begin
            dur_q <= dur_d;
            if (accept) begin
              chk_q <= chk_q + 1'b1;
              if (mismatch) begin
                err_q <= err_sat_add(err_q, (IDX_W+1)'(1));
                if (!fev_q) begin
                  fev_q   <= 1'b1;
                  fidx_q  <= chk_q[IDX_W-1:0];
                  fdata_q <= dm_d;
                end
              end
            end
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign bus.error_num       = err_q;
  assign bus.duration        = dur_q;
  assign bus.finish          = fin_q;
  assign bus.timed_out       = to_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fidx_q;
  assign bus.first_err_data  = fdata_q;
  assign bus.checked         = chk_q;
endmodule
